// File: rtl/tt_conn_tester.sv
// Harness-side connectivity tester: drives a loopback user design through the mux,
// walks 36 vectors across ui_in and uio_in, and records pass/fail, error count and first failure.
module tt_conn_tester #(
  parameter int LATENCY    = 2,
  parameter int RST_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] ui_in_drv,
  output logic [7:0] uio_in_drv,
  output logic       dut_rst_n,
  output logic       dut_ena,
  input  logic [7:0] uo_out_obs,
  input  logic [7:0] uio_oe_obs,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [5:0] first_fail_idx,
  output logic [7:0] first_fail_obs,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DUT_RST = 2'd1,
    APPLY   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] RST_LAST = 4'(RST_CYCLES);
  localparam logic [3:0] LAT_LAST = 4'(LATENCY);
  localparam logic [5:0] VEC_LAST = 6'd35;

  state_t     state, state_nxt;
  logic [3:0] cyc_cnt;
  logic [5:0] vec_idx;
  logic       rst_last;
  logic       cmp_now;
  logic       last_vec;
  logic       vec_err;
  logic       err_hit;

  // P(j): walking one, walking zero, all-zero, all-one.
  function automatic logic [7:0] vec_pat(input logic [4:0] j);
    logic [7:0] p;
    if (j < 5'd8)       p = 8'h01 << j[2:0];
    else if (j < 5'd16) p = ~(8'h01 << j[2:0]);
    else if (j == 5'd16) p = 8'h00;
    else                p = 8'hFF;
    return p;
  endfunction

  // Returns {ui_in, uio_in} for vector k: phase A exercises ui_in, phase B uio_in.
  function automatic logic [15:0] vec_drives(input logic [5:0] k);
    logic [5:0]  kb;
    logic [15:0] d;
    kb = k - 6'd18;
    if (k < 6'd18) d = {vec_pat(k[4:0]), 8'h00};
    else           d = {8'h00, vec_pat(kb[4:0])};
    return d;
  endfunction

  assign rst_last  = (state == DUT_RST) && (cyc_cnt == RST_LAST);
  assign cmp_now   = (state == APPLY) && (cyc_cnt == LAT_LAST);
  assign last_vec  = (vec_idx == VEC_LAST);
  assign vec_err   = (uo_out_obs != (ui_in_drv | uio_in_drv)) || (uio_oe_obs != 8'h00);
  assign err_hit   = cmp_now && vec_err;
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = DUT_RST;
      DUT_RST:    if (rst_last) state_nxt = APPLY;
      APPLY:      if (cmp_now && last_vec) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cyc_cnt        <= '0;
      vec_idx        <= '0;
      ui_in_drv      <= '0;
      uio_in_drv     <= '0;
      dut_rst_n      <= 1'b1;
      dut_ena        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= '0;
      first_fail_obs <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: begin
          // dut_rst_n falls on the following edge, so the entry cycle accounts for the leading 1
          // in the run length and the DUT sees exactly RST_CYCLES of reset.
          if (start) begin
            busy           <= 1'b1;
            dut_ena        <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '0;
            first_fail_obs <= '0;
            cyc_cnt        <= '0;
            vec_idx        <= '0;
          end
        end
        DUT_RST: begin
          if (rst_last) begin
            dut_rst_n                <= 1'b1;
            cyc_cnt                  <= '0;
            vec_idx                  <= '0;
            {ui_in_drv, uio_in_drv}  <= vec_drives(6'd0);
          end else begin
            dut_rst_n <= 1'b0;
            cyc_cnt   <= cyc_cnt + 4'd1;
          end
        end
        APPLY: begin
          if (cmp_now) begin
            if (err_hit) begin
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              if (err_count == 8'h00) begin
                first_fail_idx <= vec_idx;
                first_fail_obs <= uo_out_obs;
              end
            end
            cyc_cnt <= '0;
            if (last_vec) begin
              busy       <= 1'b0;
              dut_ena    <= 1'b0;
              done       <= 1'b1;
              pass       <= (err_count == 8'h00) && !vec_err;
              ui_in_drv  <= '0;
              uio_in_drv <= '0;
            end else begin
              vec_idx                 <= vec_idx + 6'd1;
              {ui_in_drv, uio_in_drv} <= vec_drives(vec_idx + 6'd1);
            end
          end else begin
            cyc_cnt <= cyc_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
